instr_fetch_queue: RTL and testbench

Fetch stage that sits directly upstream of the decode/control and immediate-extension logic. It owns the PC, issues word fetches to instruction memory, and buffers returned instructions with their PCs in a small in-order queue. It presents them to decode over a valid/ready handshake, so Instr[31:7] and the instruction PC are stable for the immediate extender and PC-target adder. Redirects (taken branch/jump, PCTarget = PC + ImmExt) flush the queue and discard in-flight responses.

---
 rtl/instr_fetch_queue.sv | 151 +++++++++++++++
 tb/tb_instr_fetch_queue.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
//   Fetch stage feeding decode. Owns the fetch PC, issues word fetches to
//   instruction memory under a credit limit, and buffers returned instructions
//   together with their PCs in a small in-order queue. Decode consumes the
//   queue head over a valid/ready handshake. A redirect flushes the queue and
//   marks every response still in flight as stale so it is discarded on return.
//
// Parameters
//   DEPTH     queue entries; also the cap on queued plus outstanding fetches
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk, reset                    rising-edge clock, async active-high reset
//   imem_req/imem_addr/imem_gnt   fetch request channel
//   imem_rvalid/imem_rdata        in-order fetch responses
//   redirect/redirect_pc          flush and restart fetch at redirect_pc
//   instr_valid/instr/instr_pc    queue head towards decode
//   instr_ready                   decode accepts the head
//   misalign_err                  sticky misaligned-redirect flag
//
// Configuration
//   IFQ_MISALIGN_CHK_EN  when defined, a redirect to a non-word-aligned PC sets
//                        misalign_err; otherwise misalign_err is tied low.
//                        Redirect targets are word-aligned in both builds.

module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        misalign_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]   DEPTH_EXT = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];

  logic [31:0] aligned_pc;
  logic        issue;
  logic        push;
  logic        pop;

  // Redirect targets are always forced onto a word boundary.
  assign aligned_pc = redirect_pc & ~32'h3;

  // A new request is only offered while queued entries plus in-flight fetches
  // leave room, so every response is guaranteed a free slot when it returns.
  assign imem_req  = !reset && !redirect &&
                     (({1'b0, count} + {1'b0, outstanding}) < DEPTH_EXT);
  assign imem_addr = fetch_pc;
  assign issue     = imem_req && imem_gnt;

  // Redirect wins over push and pop: the response arriving in the redirect
  // cycle is stale and the queue is being emptied anyway.
  assign push = imem_rvalid && (drop_cnt == '0) && !redirect;
  assign pop  = instr_valid && instr_ready && !redirect;

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? q_instr[head_ptr] : 32'h0000_0013;
  assign instr_pc    = instr_valid ? q_pc[head_ptr]    : 32'h0000_0000;

  // Control state: PCs, queue pointers, occupancy, in-flight and stale-response
  // counters. Outstanding drops on every returning response, stale or not.
  // On redirect, every response still in flight becomes stale; outstanding
  // already includes earlier stale ones, so it alone is the new drop count,
  // less the response being discarded in this very cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      head_ptr    <= '0;
      tail_ptr    <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(issue) - CW'(imem_rvalid);
      if (redirect) begin
        fetch_pc <= aligned_pc;
        resp_pc  <= aligned_pc;
        head_ptr <= '0;
        tail_ptr <= '0;
        count    <= '0;
        drop_cnt <= outstanding - CW'(imem_rvalid);
      end else begin
        if (issue) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (push) begin
          resp_pc  <= resp_pc + 32'd4;
          tail_ptr <= tail_ptr + PW'(1);
        end
        if (imem_rvalid && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
        if (pop) begin
          head_ptr <= head_ptr + PW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Queue storage needs no reset; entries are only visible while count says so.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[tail_ptr] <= imem_rdata;
      q_pc[tail_ptr]    <= resp_pc;
    end
  end

`ifdef IFQ_MISALIGN_CHK_EN
  // Sticky flag raised by any redirect whose target is not word aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_err <= 1'b0;
    end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
      misalign_err <= 1'b1;
    end
  end
`else
  assign misalign_err = 1'b0;
`endif

  // The credit limit must make a push into a full queue impossible.
  assert property (@(posedge clk) disable iff (reset) !(push && (count == DEPTH_CNT)));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue
//   Directed bench for instr_fetch_queue (DEPTH=4, RESET_PC=0). A small memory
//   model answers each accepted fetch one cycle later with the fetch address as
//   data, and can be paused to hold responses back. Expected PCs and cycle
//   counts are worked out by hand for each scenario.

module tb_instr_fetch_queue;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        misalign_err;

  int          checks;
  int          errors;
  int          issued_cnt;
  bit          mem_en;
  logic [31:0] pend [$];

  instr_fetch_queue dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .misalign_err(misalign_err)
  );

  // 10-time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something stalls forever
  initial begin
    #50000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Counts one comparison and reports it when it does not hold
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advances one clock; issues are sampled mid-cycle, then the memory model
  // decides the response for the following cycle
  task automatic applyStimulus;
    logic        iss;
    logic [31:0] a;
    @(negedge clk);
    iss = imem_req & imem_gnt;
    a   = imem_addr;
    if (iss) issued_cnt++;
    @(posedge clk);
    #1;
    if (iss) pend.push_back(a);
    if (mem_en && pend.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pend.pop_front();
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
  endtask

  // Asserts reset a little after an edge, holds it two cycles, releases it
  task automatic applyReset;
    @(posedge clk);
    #1;
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    pend.delete();
    repeat (2) @(posedge clk);
    #1;
    reset      = 1'b0;
    issued_cnt = 0;
  endtask

  // Clocks until the queue head is valid, bounded at 20 cycles
  task automatic waitValid(input string tag, output int n);
    n = 0;
    while (!instr_valid && n < 20) begin
      applyStimulus();
      n++;
    end
    checkOutput(tag, {31'b0, instr_valid}, 32'h1);
  endtask

  initial begin
    int n;
    checks      = 0;
    errors      = 0;
    issued_cnt  = 0;
    mem_en      = 1'b0;
    reset       = 1'b1;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid",   {31'b0, instr_valid},  32'h0);
    checkOutput("rst_req",     {31'b0, imem_req},     32'h0);
    checkOutput("rst_addr",    imem_addr,             32'h0);
    checkOutput("rst_instr",   instr,                 32'h0000_0013);
    checkOutput("rst_pc",      instr_pc,              32'h0);
    checkOutput("rst_misalgn", {31'b0, misalign_err}, 32'h0);

    // Streaming: two-cycle fill, then one instruction per cycle
    applyReset();
    imem_gnt = 1'b1; instr_ready = 1'b1; mem_en = 1'b1;
    applyStimulus();
    checkOutput("fill_not_yet", {31'b0, instr_valid}, 32'h0);
    applyStimulus();
    for (int i = 0; i < 4; i++) begin
      checkOutput("stream_valid", {31'b0, instr_valid}, 32'h1);
      checkOutput("stream_pc",    instr_pc, 32'(4 * i));
      checkOutput("stream_instr", instr,    32'(4 * i));
      applyStimulus();
    end

    // Back-pressure: exactly DEPTH issues, then in-order drain
    applyReset();
    imem_gnt = 1'b1; instr_ready = 1'b0; mem_en = 1'b1;
    repeat (10) applyStimulus();
    checkOutput("bp_issues", 32'(issued_cnt), 32'd4);
    checkOutput("bp_req",    {31'b0, imem_req},    32'h0);
    checkOutput("bp_valid",  {31'b0, instr_valid}, 32'h1);
    checkOutput("bp_head",   instr_pc, 32'h0);
    instr_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      applyStimulus();
      checkOutput("bp_drain_pc", instr_pc, 32'(4 * k));
    end

    // Redirect with three fetches outstanding: all three stale responses dropped
    applyReset();
    imem_gnt = 1'b1; instr_ready = 1'b1; mem_en = 1'b0;
    repeat (3) applyStimulus();
    redirect = 1'b1; redirect_pc = 32'h100;
    applyStimulus();
    redirect = 1'b0; mem_en = 1'b1;
    checkOutput("rd3_flush",  {31'b0, instr_valid}, 32'h0);
    checkOutput("rd3_addr",   imem_addr, 32'h100);
    waitValid("rd3_valid", n);
    checkOutput("rd3_cycles", 32'(n), 32'd5);
    checkOutput("rd3_pc",     instr_pc, 32'h100);
    checkOutput("rd3_instr",  instr,    32'h100);
    applyStimulus();
    checkOutput("rd3_pc2", instr_pc, 32'h104);
    applyStimulus();
    checkOutput("rd3_pc3", instr_pc, 32'h108);

    // Redirect coinciding with a response and a pop
    applyReset();
    imem_gnt = 1'b1; instr_ready = 1'b0; mem_en = 1'b0;
    repeat (2) applyStimulus();
    mem_en = 1'b1;
    repeat (2) applyStimulus();
    checkOutput("rdc_pre_valid", {31'b0, instr_valid}, 32'h1);
    checkOutput("rdc_pre_rv",    {31'b0, imem_rvalid}, 32'h1);
    redirect = 1'b1; redirect_pc = 32'h200; instr_ready = 1'b1;
    applyStimulus();
    redirect = 1'b0;
    checkOutput("rdc_empty", {31'b0, instr_valid}, 32'h0);
    checkOutput("rdc_addr",  imem_addr, 32'h200);
    waitValid("rdc_valid", n);
    checkOutput("rdc_cycles", 32'(n), 32'd3);
    checkOutput("rdc_pc",     instr_pc, 32'h200);
    checkOutput("rdc_instr",  instr,    32'h200);
    applyStimulus();
    checkOutput("rdc_pc2", instr_pc, 32'h204);

    // Fetch PC wraps from the top of the address space
    applyReset();
    imem_gnt = 1'b0; instr_ready = 1'b0; mem_en = 1'b0;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    applyStimulus();
    redirect = 1'b0;
    checkOutput("wrap_a0", imem_addr, 32'hFFFF_FFF8);
    imem_gnt = 1'b1;
    applyStimulus();
    checkOutput("wrap_a1", imem_addr, 32'hFFFF_FFFC);
    applyStimulus();
    checkOutput("wrap_a2", imem_addr, 32'h0000_0000);
    mem_en = 1'b1; instr_ready = 1'b1;
    waitValid("wrap_valid", n);
    checkOutput("wrap_pc0", instr_pc, 32'hFFFF_FFF8);
    applyStimulus();
    checkOutput("wrap_pc1", instr_pc, 32'hFFFF_FFFC);
    applyStimulus();
    checkOutput("wrap_pc2", instr_pc, 32'h0000_0000);
    checkOutput("wrap_ins2", instr,   32'h0000_0000);

    // Reset in the middle of a burst takes effect without a clock edge
    applyReset();
    imem_gnt = 1'b1; instr_ready = 1'b0; mem_en = 1'b1;
    repeat (3) applyStimulus();
    checkOutput("mid_valid_pre", {31'b0, instr_valid}, 32'h1);
    checkOutput("mid_pc_pre",    instr_pc, 32'h0);
    #2;
    reset = 1'b1;
    imem_rvalid = 1'b0;
    pend.delete();
    #1;
    checkOutput("mid_valid", {31'b0, instr_valid}, 32'h0);
    checkOutput("mid_addr",  imem_addr, 32'h0);
    checkOutput("mid_req",   {31'b0, imem_req}, 32'h0);
    checkOutput("mid_instr", instr, 32'h0000_0013);

    // Misaligned redirect: target is word-aligned, flag depends on build
    applyReset();
    imem_gnt = 1'b0; instr_ready = 1'b0; mem_en = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h102;
    applyStimulus();
    redirect = 1'b0;
    checkOutput("mis_addr", imem_addr, 32'h100);
`ifdef IFQ_MISALIGN_CHK_EN
    checkOutput("mis_flag", {31'b0, misalign_err}, 32'h1);
    applyStimulus();
    checkOutput("mis_sticky", {31'b0, misalign_err}, 32'h1);
`else
    checkOutput("mis_flag", {31'b0, misalign_err}, 32'h0);
    applyStimulus();
    checkOutput("mis_sticky", {31'b0, misalign_err}, 32'h0);
`endif
    applyReset();
    checkOutput("mis_clear", {31'b0, misalign_err}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
